// File: rtl/spart_tx.sv
// SPART transmit stage: programmable baud generator, one-byte holding
// register and a start/8-data/stop serial shifter driving txd.
module spart_tx #(
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd162,
  parameter int          OVERSAMPLE      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] write_line,
  input  logic       transmit_write_en,
  input  logic       baud_write_en,
  input  logic       baud_write_location,
  output logic       tbr,
  output logic       txd,
  output logic       baud_en,
  output logic       tx_busy
);

  localparam int                OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]   OS_LAST = OS_W'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [15:0]     divisor;
  logic [15:0]     baud_cnt;
  logic [7:0]      hold;
  logic            hold_full;
  logic [7:0]      shifter;
  logic [OS_W-1:0] os_cnt;
  logic [2:0]      bit_idx;
  logic            txd_q;
  logic            bit_end;
  logic            transfer;

  assign baud_en  = (baud_cnt == 16'd0);
  assign bit_end  = baud_en && (os_cnt == OS_LAST);
  assign transfer = hold_full && ((state == IDLE) || ((state == STOP) && bit_end));
  assign tbr      = !hold_full;
  assign txd      = txd_q;
  assign tx_busy  = (state != IDLE);

  // A divisor write restarts the count from the full new value, so the
  // new rate applies from the very next enable period.
  always_ff @(posedge clk) begin
    if (rst) begin
      divisor  <= DEFAULT_DIVISOR;
      baud_cnt <= DEFAULT_DIVISOR;
    end else if (baud_write_en) begin
      if (baud_write_location) begin
        divisor[15:8] <= write_line;
        baud_cnt      <= {write_line, divisor[7:0]};
      end else begin
        divisor[7:0] <= write_line;
        baud_cnt     <= {divisor[15:8], write_line};
      end
    end else if (baud_en) begin
      baud_cnt <= divisor;
    end else begin
      baud_cnt <= baud_cnt - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold      <= 8'h00;
      hold_full <= 1'b0;
    end else if (transfer) begin
      hold_full <= 1'b0;
    end else if (transmit_write_en && !hold_full) begin
      hold      <= write_line;
      hold_full <= 1'b1;
    end
  end

  // Shifter FSM; txd is registered so each bit appears the cycle after
  // the enable that starts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      txd_q   <= 1'b1;
      os_cnt  <= '0;
      bit_idx <= 3'd0;
      shifter <= 8'h00;
    end else if (transfer) begin
      shifter <= hold;
      os_cnt  <= '0;
      state   <= START;
      txd_q   <= 1'b0;
    end else begin
      if (baud_en && (state != IDLE)) begin
        os_cnt <= bit_end ? '0 : os_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          txd_q <= 1'b1;
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= 3'd0;
            txd_q   <= shifter[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd_q <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd_q   <= shifter[bit_idx + 3'd1];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spart_tx.sv
// Bench for spart_tx: a frame-level reference model checked every cycle,
// plus literal run-length and timing checks from the serial line.
module tb_spart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] write_line = 8'h00;
  logic       transmit_write_en = 1'b0;
  logic       baud_write_en = 1'b0;
  logic       baud_write_location = 1'b0;
  logic       tbr, txd, baud_en, tx_busy;

  int vectors = 0;
  int miscompares = 0;

  spart_tx dut (
    .clk(clk),
    .rst(rst),
    .write_line(write_line),
    .transmit_write_en(transmit_write_en),
    .baud_write_en(baud_write_en),
    .baud_write_location(baud_write_location),
    .tbr(tbr),
    .txd(txd),
    .baud_en(baud_en),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // Reference model: absolute cycle of the next enable, and a frame as a
  // 10-bit pattern indexed by how many enables it has consumed.
  bit         m_valid = 1'b0;
  int         m_cyc, m_next_en, m_div;
  bit         m_full, m_active;
  logic [7:0] m_hold;
  logic [9:0] m_bits;
  int         m_ticks;

  always @(posedge clk) begin
    bit en_now, write_ok, full_pre;
    if (rst) begin
      m_valid = 1'b1;
      m_cyc = 0; m_div = 162; m_next_en = 162;
      m_full = 1'b0; m_active = 1'b0; m_ticks = 0; m_hold = 8'h00; m_bits = 10'h3ff;
    end else if (m_valid) begin
      en_now   = (m_cyc == m_next_en);
      full_pre = m_full;
      write_ok = transmit_write_en && !full_pre;
      if (m_active && en_now) begin
        m_ticks++;
        if (m_ticks == 160) begin
          if (full_pre) begin
            m_bits = {1'b1, m_hold, 1'b0}; m_ticks = 0; m_full = 1'b0;
          end else begin
            m_active = 1'b0;
          end
        end
      end else if (!m_active && full_pre) begin
        m_bits = {1'b1, m_hold, 1'b0}; m_ticks = 0; m_full = 1'b0; m_active = 1'b1;
      end
      if (write_ok) begin
        m_hold = write_line; m_full = 1'b1;
      end
      if (baud_write_en) begin
        if (baud_write_location) m_div = (m_div & 32'h00ff) | (int'(write_line) << 8);
        else                     m_div = (m_div & 32'hff00) | int'(write_line);
        m_next_en = m_cyc + 1 + m_div;
      end else if (en_now) begin
        m_next_en = m_cyc + 1 + m_div;
      end
      m_cyc++;
    end
  end

  task automatic checkOutput();
    logic e_txd, e_tbr, e_en, e_busy;
    e_txd  = m_active ? m_bits[m_ticks / 16] : 1'b1;
    e_tbr  = !m_full;
    e_en   = (m_cyc == m_next_en);
    e_busy = m_active;
    vectors++;
    if (txd !== e_txd || tbr !== e_tbr || baud_en !== e_en || tx_busy !== e_busy) begin
      miscompares++;
      $display("[TB] FAIL cycle_model at %0t: got txd=%b tbr=%b baud_en=%b tx_busy=%b, expected txd=%b tbr=%b baud_en=%b tx_busy=%b",
               $time, txd, tbr, baud_en, tx_busy, e_txd, e_tbr, e_en, e_busy);
    end
  endtask

  // Negedge monitor: model comparison, enable spacing and txd run lengths.
  int neg_cnt = 0, en_prev = 0, en_last = 0;
  logic prev_txd = 1'b1;
  int run_len = 0;
  int run_len_q[$];
  logic run_val_q[$];

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput();
      neg_cnt++;
      if (baud_en) begin
        en_prev = en_last; en_last = neg_cnt;
      end
      if (txd === prev_txd) begin
        run_len++;
      end else begin
        run_len_q.push_back(run_len);
        run_val_q.push_back(prev_txd);
        run_len = 1;
        prev_txd = txd;
      end
    end
  end

  task automatic check_literal(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_range(input string name, input int actual, input int lo, input int hi);
    vectors++;
    if (actual < lo || actual > hi) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // kind 0 = TX byte, 1 = divisor low, 2 = divisor high
  task automatic applyStimulus(input int kind, input logic [7:0] data);
    write_line = data;
    transmit_write_en   = (kind == 0);
    baud_write_en       = (kind != 0);
    baud_write_location = (kind == 2);
    @(posedge clk); #1;
    transmit_write_en = 1'b0;
    baud_write_en     = 1'b0;
  endtask

  task automatic wait_tbr(input int limit);
    int n = 0;
    while (!tbr && n < limit) begin
      @(posedge clk); #1; n++;
    end
    if (!tbr) check_literal("wait_tbr_timeout", 0, 1);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while ((tx_busy || !tbr) && n < limit) begin
      @(posedge clk); #1; n++;
    end
    if (tx_busy || !tbr) check_literal("wait_done_timeout", 0, 1);
  endtask

  task automatic clear_runs();
    run_len_q.delete();
    run_val_q.delete();
  endtask

  initial begin
    $display("[TB] spart_tx bench starting");
    rst = 1'b1;
    idle(3);
    check_literal("reset_tbr", int'(tbr), 1);
    check_literal("reset_txd", int'(txd), 1);
    check_literal("reset_busy", int'(tx_busy), 0);
    check_literal("reset_baud_en", int'(baud_en), 0);
    rst = 1'b0;
    idle(400);
    check_literal("default_period", en_last - en_prev, 163);
    check_literal("idle_txd", int'(txd), 1);

    applyStimulus(1, 8'h03);
    applyStimulus(2, 8'h00);
    idle(20);
    check_literal("div3_period", en_last - en_prev, 4);
    idle($urandom_range(0, 3));
    clear_runs();
    applyStimulus(0, 8'hA5);
    check_literal("a5_tbr_low", int'(tbr), 0);
    idle(1);
    check_literal("a5_tbr_back", int'(tbr), 1);
    check_literal("a5_busy", int'(tx_busy), 1);
    idle(700);
    check_literal("a5_busy_end", int'(tx_busy), 0);
    check_literal("a5_runs", run_len_q.size(), 8);
    if (run_len_q.size() == 8) begin
      check_range("a5_start_len", run_len_q[1], 61, 64);
      check_literal("a5_start_val", int'(run_val_q[1]), 0);
      check_literal("a5_d0", run_len_q[2], 64);
      check_literal("a5_d1", run_len_q[3], 64);
      check_literal("a5_d2", run_len_q[4], 64);
      check_literal("a5_d34", run_len_q[5], 128);
      check_literal("a5_d5", run_len_q[6], 64);
      check_literal("a5_d5_val", int'(run_val_q[6]), 1);
      check_literal("a5_d6", run_len_q[7], 64);
    end

    clear_runs();
    applyStimulus(0, 8'h55);
    wait_tbr(10);
    applyStimulus(0, 8'h0F);
    applyStimulus(0, 8'hFF);
    idle(1500);
    check_literal("b2b_runs", run_len_q.size(), 14);
    if (run_len_q.size() == 14) begin
      check_literal("b2b_stop1", run_len_q[10], 64);
      check_literal("b2b_start2", run_len_q[11], 64);
      check_literal("b2b_ones", run_len_q[12], 256);
      check_literal("b2b_zeros", run_len_q[13], 256);
    end

    applyStimulus(0, 8'h00);
    idle(288);
    applyStimulus(1, 8'h07);
    idle(1300);
    check_literal("div7_period", en_last - en_prev, 8);
    check_literal("div7_done", int'(tx_busy), 0);

    applyStimulus(1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      check_literal("div0_baud_en", int'(baud_en), 1);
      idle(1);
    end
    clear_runs();
    applyStimulus(0, 8'h81);
    idle(200);
    check_literal("x81_runs", run_len_q.size(), 4);
    if (run_len_q.size() == 4) begin
      check_literal("x81_start", run_len_q[1], 16);
      check_literal("x81_d0", run_len_q[2], 16);
      check_literal("x81_d1_6", run_len_q[3], 96);
    end

    for (int f = 0; f < 6; f++) begin
      applyStimulus(1, 8'($urandom_range(0, 3)));
      idle($urandom_range(0, 7));
      applyStimulus(0, 8'($urandom));
      idle($urandom_range(0, 40));
      applyStimulus(0, 8'($urandom));
      wait_done(4000);
    end

    applyStimulus(1, 8'h03);
    applyStimulus(0, 8'h3C);
    wait_tbr(10);
    applyStimulus(0, 8'hC3);
    idle(200);
    check_literal("pending_tbr", int'(tbr), 0);
    rst = 1'b1;
    idle(1);
    check_literal("midreset_txd", int'(txd), 1);
    check_literal("midreset_tbr", int'(tbr), 1);
    check_literal("midreset_busy", int'(tx_busy), 0);
    rst = 1'b0;
    idle(2);
    clear_runs();
    idle(2000);
    check_literal("postreset_no_frame", run_len_q.size(), 0);
    check_literal("postreset_period", en_last - en_prev, 163);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spart_tx.md
Name: spart_tx

Overview:
- Transmit stage of the SPART, directly downstream of the bus interface.
- Consumes the bus interface's write_line/transmit_write_en and baud_write_en/baud_write_location strobes.
- Returns tbr to the bus interface and drives the serial txd line.
- Owns the programmable 16-bit baud divisor and generates the oversample enable, which is exported for the receive stage.

Parameters:
DEFAULT_DIVISOR, 16'd162, divisor loaded at reset (about 19200 baud x16 at 50 MHz)
OVERSAMPLE, 16, baud enables per serial bit

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
write_line  input  8  write data from the bus interface (byte to transmit, or divisor byte)
transmit_write_en  input  1  one-cycle strobe: write_line is a TX byte
baud_write_en  input  1  one-cycle strobe: write_line is a divisor byte
baud_write_location  input  1  0 = divisor low byte, 1 = divisor high byte
tbr  output  1  transmit buffer ready (holding register empty)
txd  output  1  serial output, idle high
baud_en  output  1  one-cycle oversample enable, shared with the receive stage
tx_busy  output  1  shifter state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values:
  - divisor = DEFAULT_DIVISOR; baud counter = DEFAULT_DIVISOR.
  - holding register empty, so tbr=1.
  - state = IDLE; txd=1; baud_en=0; tx_busy=0.
  - oversample count = 0; bit index = 0.
- Divisor writes:
  - baud_write_en with location 0 writes divisor[7:0]; with location 1 writes divisor[15:8].
  - The new value takes effect at the next clock edge.
  - The same edge reloads the baud counter with the full updated divisor.
  - Writes are accepted in any state. A write mid-frame changes timing of the remaining bits only.
- Baud generator:
  - Free-running down-counter.
  - When the counter == 0: baud_en=1 for that cycle, and the counter reloads the divisor at the next edge.
  - Otherwise the counter decrements.
  - Enable period = divisor+1 clocks. Divisor 0 gives baud_en every cycle.
  - The counter is never resynchronised to frame start.
- Holding register:
  - transmit_write_en while tbr=1 stores write_line; tbr=0 from the next cycle.
  - transmit_write_en while tbr=0 is ignored; the byte is dropped and stored data is unchanged.
  - tbr = holding register empty.
- Transfer to the shifter occurs on an edge where the holding register is full and either:
  - state == IDLE, or
  - state == STOP and this cycle is the final baud_en of the stop bit.
- On transfer: the shifter loads the byte, the holding register empties (tbr=1 next cycle), oversample count = 0, state -> START.
- Write arriving in the same cycle as a transfer: not possible, since tbr=0 during that cycle, so the write is dropped.
- FSM (oversample count increments on each baud_en; a bit ends on the baud_en where count == OVERSAMPLE-1, and count then wraps to 0):
  - IDLE: txd=1. Exits only via transfer.
  - START: txd=0. At bit end -> DATA, bit index = 0.
  - DATA: txd = shifter[bit index], LSB first. At bit end, bit index++. After bit 7 ends -> STOP.
  - STOP: txd=1. At bit end: transfer if the holding register is full (back-to-back frame, no idle gap), else -> IDLE.
- Frame timing:
  - Frame = 10 bits. Each bit after start = OVERSAMPLE*(divisor+1) clocks.
  - Start bit lasts between (OVERSAMPLE-1)*(divisor+1)+1 and OVERSAMPLE*(divisor+1) clocks, depending on baud phase.
- txd is registered. The first transfer from IDLE drives txd low one cycle after the transfer edge.
- Latency: a write to an empty register with the shifter IDLE gives tbr=0 for exactly one cycle, then tbr=1 while the frame shifts.
- Reset asserted mid-frame: on the next edge all state returns to reset values, txd=1 immediately, the pending byte is lost, and the divisor returns to DEFAULT_DIVISOR.

Test Plan:
- Reset, idle 100 cycles -> txd=1, tbr=1, tx_busy=0; baud_en pulses every 163 clocks.
- Divisor writes:
  - write 0x03 at location 0, then 0x00 at location 1 -> baud_en every 4 clocks from the next edge.
  - then transmit 0xA5 -> txd bit sequence 0,1,0,1,0,0,1,0,1,1, each bit after start 64 clocks.
  - tbr=0 for one cycle after the write, then 1; tx_busy falls after the stop bit.
- Back-to-back, divisor 3: write 0x55; when tbr returns 1, write 0x0F.
  - Third write of 0xFF while tbr=0 is dropped.
  - Frames 0x55 then 0x0F with no idle between stop and start; 0xFF never appears.
- Divisor change mid-frame: divisor 3, send 0x00; during bit 3 write divisor low = 7 -> remaining bits last 128 clocks; earlier bits 64.
- Divisor 0 edge case: baud_en stuck high; send 0x81 -> 16-clock bits, correct sequence.
- Reset mid-DATA with a byte pending in the holding register -> next cycle txd=1, tbr=1, state IDLE, divisor = 162; no further frame is emitted.
